// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the RGB PWM LED driver: widths and blink FSM states.
package rgb_pwm_pkg;

  localparam int PWM_BITS = 8;
  localparam int LED_BITS = 6;

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2
  } blink_state_t;

endpackage

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: clock prescaler, 8-bit PWM counter and period boundary detect.
module rgb_pwm_timebase
  import rgb_pwm_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                tick,
  output logic [PWM_BITS-1:0] cnt,
  output logic                boundary
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick     = (pre == PRE_MAX);
  assign boundary = tick && (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Two-LED RGB PWM driver with period-aligned duty/colour updates and blink FSM.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int BLINK_PERIODS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LED_BITS-1:0] color_in,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic                duty_load,
  input  logic                blink_en,
  output logic [LED_BITS-1:0] led_out,
  output logic                period_start
);

  localparam logic [9:0] PHASE_LAST = 10'(BLINK_PERIODS - 1);

  logic                tick;
  logic                boundary;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_pend;
  logic [PWM_BITS-1:0] duty_act;
  logic [LED_BITS-1:0] color_q;
  logic [9:0]          phase;
  blink_state_t        state;
  logic                lit;

  rgb_pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .cnt     (cnt),
    .boundary(boundary)
  );

  assign lit = (cnt < duty_act) && (state != BLINK_OFF);

  // A load coinciding with the boundary must land in this period, so it bypasses duty_pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_pend    <= '0;
      duty_act     <= '0;
      color_q      <= '0;
      period_start <= 1'b0;
      led_out      <= '0;
    end else begin
      if (duty_load) duty_pend <= duty_in;
      if (boundary) begin
        duty_act <= duty_load ? duty_in : duty_pend;
        color_q  <= color_in;
      end
      period_start <= boundary;
      led_out      <= lit ? color_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SOLID;
      phase <= '0;
    end else if (boundary) begin
      case (state)
        SOLID: begin
          if (blink_en) begin
            state <= BLINK_ON;
            phase <= '0;
          end
        end
        BLINK_ON, BLINK_OFF: begin
          if (!blink_en) begin
            state <= SOLID;
            phase <= '0;
          end else if (phase == PHASE_LAST) begin
            state <= (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            phase <= '0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state <= SOLID;
          phase <= '0;
        end
      endcase
    end
  end

  a_boundary_on_tick : assert property (@(posedge clk) disable iff (!rst_n) boundary |-> tick);

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: clocks per PWM tick, range 1..256.
REQ-002 Parameter BLINK_PERIODS, default 8: PWM periods per blink phase, range 1..1024.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 color_in  input  6  on/off colour mask from the LED selector; [2:0] = LED0 {B,G,R}, [5:3] = LED1 {B,G,R}.
REQ-006 duty_in  input  8  requested brightness, 0 = off, 255 = 255/256 on.
REQ-007 duty_load  input  1  single-cycle strobe; captures duty_in.
REQ-008 blink_en  input  1  level; 1 requests blinking, 0 requests solid output.
REQ-009 led_out  output  6  registered PWM-gated LED drive, same bit map as color_in.
REQ-010 period_start  output  1  one-cycle pulse marking the first clock of each PWM period.

Function
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and assert tick on the cycle it equals CLK_DIV-1, then wrap to 0.
REQ-012 8-bit PWM counter cnt SHALL increment on tick only; 255 wraps to 0; one period = 256*CLK_DIV clocks.
REQ-013 Period boundary SHALL be the cycle where tick=1 and cnt=255.
REQ-014 duty_load=1 SHALL write duty_in into duty_pend that cycle; several loads in one period: last wins.
REQ-015 At a period boundary, duty_act <= duty_pend and color_q <= color_in; mid-period changes to color_in or duty_in SHALL NOT affect the current period.
REQ-016 A duty_load on the boundary cycle itself SHALL be applied at that boundary (pending write bypasses to duty_act).
REQ-017 led_out[i] SHALL register color_q[i] AND (cnt < duty_act) AND (state != BLINK_OFF); latency one clock from cnt.
REQ-018 duty_act=0 SHALL hold led_out at 0; duty_act=255 SHALL give 255 on-ticks per 256.
REQ-019 period_start SHALL pulse high for exactly one clock, the cycle after each boundary.
REQ-020 Blink FSM states: SOLID, BLINK_ON, BLINK_OFF; transitions evaluated only at period boundaries.
REQ-021 SOLID -> BLINK_ON when blink_en=1; phase counter cleared.
REQ-022 BLINK_ON <-> BLINK_OFF toggle after BLINK_PERIODS boundaries in the current phase; phase counter cleared on toggle.
REQ-023 Any blink state -> SOLID when blink_en=0 at a boundary; a blink_en pulse shorter than a period and not spanning a boundary SHALL be ignored.
REQ-024 Phase counter SHALL be 10 bits and saturate-free: it never exceeds BLINK_PERIODS-1.

Reset
REQ-025 rst_n=0 SHALL immediately force led_out=0, period_start=0, prescaler=0, cnt=0, duty_pend=0, duty_act=0, color_q=0, phase counter=0, state=SOLID.
REQ-026 Reset asserted mid-period SHALL abandon the period; after release the first boundary occurs 256*CLK_DIV clocks later.
REQ-027 Release of rst_n needs no synchronisation inside this block; the integrating top synchronises deassertion.

Structure
REQ-028 Shared package rgb_pwm_pkg SHALL hold the blink state enum, PWM_BITS=8 and LED_BITS=6.
REQ-029 Prescaler plus PWM counter plus boundary detect SHALL be sub-module rgb_pwm_timebase (outputs tick, cnt, boundary).
REQ-030 Target size 120-400 lines RTL; no combinational path from any input to led_out.

Verification (CLK_DIV=1, BLINK_PERIODS=2 unless stated)
REQ-031 Reset then color_in=6'b000001, duty_load with duty_in=64 -> led_out[0] high exactly 64 of 256 clocks from the second period on; other bits 0.
REQ-032 duty_in=0 then 255 loaded on successive periods -> period 1 zero high cycles, period 2 exactly 255 high cycles; period_start every 256 clocks.
REQ-033 color_in changed 6'b000111 -> 6'b111000 at cnt=100 -> change visible only after the next period_start.
REQ-034 blink_en=1, duty 128, color_in=6'b111111 -> 2 periods lit, 2 periods dark, repeating; blink_en=0 -> solid from the next boundary.
REQ-035 rst_n pulled low at cnt=50 with LEDs lit -> led_out=0 in the same cycle; state SOLID, duty 0 after release.
REQ-036 CLK_DIV=4, duty 10 -> led_out high 40 clocks per 1024-clock period.
